// File: rtl/instr_dispatcher_pkg.sv
// Shared types for the instruction dispatcher: BRAM ids, op and class
// encodings, instruction field layout, NOP and the dispatcher state type.
package instr_dispatcher_pkg;

  localparam int INSTR_W = 8;
  localparam int FIELD_W = 2;

  localparam int DEST_POS = 6;
  localparam int SRC_POS  = 4;
  localparam int CLS_POS  = 2;
  localparam int OP_POS   = 0;

  localparam logic [INSTR_W-1:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } bram_e;

  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    COPY   = 2'b01,
    UNLOAD = 2'b10,
    CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CLS_SYS  = 2'b00,
    CLS_MEM  = 2'b01,
    CLS_XFER = 2'b10,
    CLS_CTRL = 2'b11
  } cls_e;

  typedef struct packed {
    bram_e dest;
    bram_e src;
    cls_e  cls;
    op_e   op;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  function automatic logic [INSTR_W-1:0] mk_instr(
    input bram_e dest,
    input bram_e src,
    input cls_e  cls,
    input op_e   op
  );
    instr_t i;
    i.dest = dest;
    i.src  = src;
    i.cls  = cls;
    i.op   = op;
    return i;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: DEPTH x 8 FIFO with push/pop/flush and occupancy count.
// Ports: clk, reset, push, pop, flush, din, dout (head), count, full, empty.
module instr_fifo
  import instr_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [INSTR_W-1:0]       din,
  output logic [INSTR_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // flush wins over both; a full queue refuses push even if popping
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_dispatcher.sv
// Queues host instructions and hands them one at a time to the FSM,
// waiting for its busy handshake. Ports: clk, reset, host_valid/instr/ready,
// flush, fsm_instruction, fsm_busy, idle, err_timeout, queue_count.
module instr_dispatcher
  import instr_dispatcher_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_valid,
  input  logic [7:0]             host_instr,
  output logic                   host_ready,
  input  logic                   flush,
  output logic [7:0]             fsm_instruction,
  input  logic                   fsm_busy,
  output logic                   idle,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e       state;
  logic [7:0]   issue_reg;
  logic [TW-1:0] to_cnt;
  logic [7:0]   head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // NOPs complete the handshake but are never stored
  assign push = host_valid && (host_instr != NOP);

  // a flushed head is discarded, not issued
  assign pop = (state == IDLE) && !empty && !fsm_busy && !flush;

  assign host_ready = !full;
  assign idle       = empty && (state == IDLE);

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (host_instr),
    .dout  (head),
    .count (queue_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      issue_reg       <= NOP;
      fsm_instruction <= NOP;
      err_timeout     <= 1'b0;
      to_cnt          <= '0;
    end else begin
      fsm_instruction <= NOP;
      unique case (state)
        IDLE: begin
          if (pop) begin
            issue_reg <= head;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          fsm_instruction <= issue_reg;
          to_cnt          <= '0;
          state           <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (fsm_busy) begin
            state <= WAIT_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!fsm_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Scoreboard bench for instr_dispatcher with a behavioural FSM responder.
// Directed scenarios followed by randomized traffic.
module tb_instr_dispatcher;
  import instr_dispatcher_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       host_valid;
  logic [7:0] host_instr;
  logic       host_ready;
  logic       flush;
  logic [7:0] fsm_instruction;
  logic       fsm_busy;
  logic       idle;
  logic       err_timeout;
  logic [$clog2(DEPTH):0] queue_count;

  instr_dispatcher #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .host_valid      (host_valid),
    .host_instr      (host_instr),
    .host_ready      (host_ready),
    .flush           (flush),
    .fsm_instruction (fsm_instruction),
    .fsm_busy        (fsm_busy),
    .idle            (idle),
    .err_timeout     (err_timeout),
    .queue_count     (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  logic mb = 1'b0;
  logic force_busy = 1'b0;
  int   pend = -1;
  int   left = 0;
  int   cur_hold = 1;
  int   hold_len = 0;
  logic noack_next = 1'b0;
  logic rand_noack = 1'b0;
  logic exp_err = 1'b0;
  logic prev_issue = 1'b0;

  assign fsm_busy = mb | force_busy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + FSM responder: every issued instruction must be the oldest
  // accepted one; the responder then raises busy (or withholds it).
  always @(negedge clk) begin : mon
    logic [7:0] e;
    int d;
    if (reset) begin
      exp_q.delete();
      mb = 1'b0;
      pend = -1;
      left = 0;
      noack_next = 1'b0;
      exp_err = 1'b0;
      prev_issue = 1'b0;
    end else begin
      if (mb) begin
        left--;
        if (left <= 0) mb = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mb = 1'b1;
          left = cur_hold;
          pend = -1;
        end
      end
      if (fsm_instruction != 8'h00) begin
        chk("issue_pulse_width", 32'(prev_issue), 0);
        chk("issue_while_busy", 32'(mb | force_busy | (pend >= 0)), 0);
        chk("unexpected_issue", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("issue_order", 32'(fsm_instruction), 32'(e));
        end
        if (noack_next || (rand_noack && $urandom_range(0, 11) == 0)) begin
          noack_next = 1'b0;
          exp_err = 1'b1;
        end else begin
          d = (hold_len != 0) ? 0 : int'($urandom_range(0, 2));
          cur_hold = (hold_len != 0) ? hold_len : int'($urandom_range(1, 6));
          if (d == 0) begin
            mb = 1'b1;
            left = cur_hold;
          end else begin
            pend = d;
          end
        end
      end
      prev_issue = (fsm_instruction != 8'h00);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    host_valid = 1'b1;
    host_instr = v;
    for (int i = 0; i < 300; i++) begin
      if (host_ready) begin
        if (v != 8'h00) exp_q.push_back(v);
        tick();
        host_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("push_timeout", 0, 1);
    host_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (idle && !fsm_busy && pend < 0 && exp_q.size() == 0) return;
      tick();
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_issue(input logic [7:0] v);
    for (int i = 0; i < 400; i++) begin
      if (fsm_instruction == v) return;
      tick();
    end
    chk("wait_issue_timeout", 0, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_fsm_instruction"}, 32'(fsm_instruction), 0);
    chk({tag, "_host_ready"}, 32'(host_ready), 1);
    chk({tag, "_idle"}, 32'(idle), 1);
    chk({tag, "_queue_count"}, 32'(queue_count), 0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] x5;
    reset = 1'b1;
    host_valid = 1'b0;
    host_instr = 8'h00;
    flush = 1'b0;
    #2;
    reset_checks("reset");
    tick();
    reset = 1'b0;
    tick();

    // single instruction latency and one-cycle pulse
    push(mk_instr(B0, B0, CLS_MEM, LOAD));
    chk("lat_t0_instr", 32'(fsm_instruction), 0);
    chk("lat_t0_count", 32'(queue_count), 1);
    tick();
    chk("lat_t1_instr", 32'(fsm_instruction), 0);
    chk("lat_t1_count", 32'(queue_count), 0);
    tick();
    chk("lat_t2_instr", 32'(fsm_instruction), 32'h04);
    tick();
    chk("lat_t3_instr", 32'(fsm_instruction), 0);
    wait_idle();

    // fill queue while FSM busy, then drain with long busy periods
    hold_len = 64;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(mk_instr(bram_e'(i[1:0]), B0, CLS_MEM, LOAD));
    chk("full_count", 32'(queue_count), 4);
    chk("full_ready", 32'(host_ready), 0);
    force_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_issue(mk_instr(bram_e'(k[1:0]), B0, CLS_MEM, LOAD));
      chk("drain_count", 32'(queue_count), 32'(3 - k));
    end
    wait_idle();
    hold_len = 0;

    // fifth push while full waits for the first pop
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(1, 255)));
    x5 = 8'($urandom_range(1, 255));
    host_valid = 1'b1;
    host_instr = x5;
    for (int i = 0; i < 2; i++) begin
      chk("full_hold_ready", 32'(host_ready), 0);
      chk("full_hold_count", 32'(queue_count), 4);
      tick();
    end
    force_busy = 1'b0;
    tick();
    chk("after_pop_count", 32'(queue_count), 3);
    chk("after_pop_ready", 32'(host_ready), 1);
    exp_q.push_back(x5);
    tick();
    host_valid = 1'b0;
    chk("fifth_accepted_count", 32'(queue_count), 4);
    wait_idle();

    // missing busy acknowledge
    noack_next = 1'b1;
    push(8'h45);
    push(8'h86);
    wait_issue(8'h45);
    chk("to_n0", 32'(err_timeout), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_pending", 32'(err_timeout), 0);
    end
    tick();
    chk("to_set", 32'(err_timeout), 1);
    wait_issue(8'h86);
    wait_idle();
    chk("to_sticky", 32'(err_timeout), 1);

    // flush with simultaneous push during WAIT_DONE
    hold_len = 40;
    push(8'h95);
    wait_issue(8'h95);
    tick();
    tick();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("pre_flush_count", 32'(queue_count), 3);
    flush = 1'b1;
    host_valid = 1'b1;
    host_instr = 8'h44;
    exp_q.delete();
    tick();
    flush = 1'b0;
    host_valid = 1'b0;
    chk("flush_count", 32'(queue_count), 0);
    chk("flush_busy_idle", 32'(idle), 0);
    wait_idle();
    chk("flush_done_idle", 32'(idle), 1);
    hold_len = 0;

    // NOP is swallowed
    push(8'h00);
    chk("nop_count", 32'(queue_count), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("nop_idle", 32'(idle), 1);

    // reset during WAIT_DONE
    hold_len = 100;
    push(8'hA7);
    wait_issue(8'hA7);
    tick();
    tick();
    push(8'h5A);
    reset = 1'b1;
    #1;
    reset_checks("midreset");
    tick();
    reset = 1'b0;
    hold_len = 0;
    tick();
    push(8'h3C);
    wait_idle();

    // random traffic
    rand_noack = 1'b1;
    for (int i = 0; i < 400; i++) begin
      host_valid = ($urandom_range(0, 1) == 1);
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      host_instr = v;
      flush = mb && ($urandom_range(0, 9) == 0);
      if (flush) exp_q.delete();
      else if (host_valid && host_ready && v != 8'h00) exp_q.push_back(v);
      tick();
    end
    host_valid = 1'b0;
    flush = 1'b0;
    rand_noack = 1'b0;
    wait_idle();
    chk("rand_err_timeout", 32'(err_timeout), 32'(exp_err));
    chk("rand_final_count", 32'(queue_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue depth, power of two, minimum 2.
REQ-002 Parameter ACK_TIMEOUT, default 4: cycles allowed for fsm_busy to rise after an issue.
REQ-003 clk  input  1  single clock; all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 host_valid  input  1  host offers host_instr this cycle.
REQ-006 host_instr  input  8  host instruction: [7:6] dest BRAM, [5:4] src BRAM, [3:2] class, [1:0] op.
REQ-007 host_ready  output  1  queue can accept; transfer occurs when host_valid && host_ready.
REQ-008 flush  input  1  synchronous: discard all queued (not yet issued) entries.
REQ-009 fsm_instruction  output  8  instruction driven to the FSM host_instruction input; 8'h00 (NOP) when not issuing.
REQ-010 fsm_busy  input  1  FSM busy flag.
REQ-011 idle  output  1  queue empty and state IDLE.
REQ-012 err_timeout  output  1  sticky: fsm_busy did not rise within ACK_TIMEOUT cycles.
REQ-013 queue_count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-014 Queue: FIFO of DEPTH 8-bit entries; host_ready = (queue_count < DEPTH).
REQ-015 A transferred instruction equal to 8'h00 is accepted and discarded (never queued, never issued).
REQ-016 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if queue non-empty and fsm_busy==0, pop head into the issue register and go to ISSUE next cycle.
REQ-018 ISSUE: fsm_instruction = issue register for exactly one cycle; next state WAIT_BUSY; timeout counter cleared.
REQ-019 WAIT_BUSY: fsm_instruction = 8'h00; fsm_busy==1 -> WAIT_DONE; else counter increments; counter reaching ACK_TIMEOUT -> set err_timeout, go IDLE.
REQ-020 WAIT_DONE: fsm_busy==0 -> IDLE; no cycle limit.
REQ-021 Issue latency: instruction written into an empty queue while IDLE and fsm_busy==0 appears on fsm_instruction exactly 2 cycles after the transfer edge.
REQ-022 Back-to-back: next issue begins no earlier than the cycle after WAIT_DONE observes fsm_busy==0 (minimum one IDLE cycle between issues).
REQ-023 Simultaneous push and pop when full: push refused (host_ready=0); pop proceeds; host_ready rises next cycle.
REQ-024 Simultaneous push and pop when non-full: both occur; queue_count unchanged.
REQ-025 Pointers wrap modulo DEPTH; queue_count distinguishes full from empty.
REQ-026 flush: clears queue (queue_count=0 next cycle) and takes priority over a same-cycle push, which is dropped; does not abort an instruction already in ISSUE/WAIT_BUSY/WAIT_DONE.
REQ-027 err_timeout clears only on reset; further issues continue after it is set.
REQ-028 fsm_instruction is registered (no combinational path from host_instr).

Reset
REQ-029 On reset assertion, asynchronously: state IDLE, queue empty, pointers 0, issue register 8'h00, fsm_instruction 8'h00, err_timeout 0, timeout counter 0.
REQ-030 Outputs during reset: host_ready 1, idle 1, queue_count 0.
REQ-031 Reset mid-operation abandons the in-flight instruction and all queued entries; the FSM is reset by the same signal.

Structure
REQ-032 Shared package holds: BRAM ids B0..B3, op encodings LOAD 2'b00 / COPY 2'b01 / UNLOAD 2'b10 / CLEAR 2'b11, class encodings, NOP 8'h00, instruction field positions.
REQ-033 One sub-module: instr_fifo (parameterised DEPTH x 8, push/pop/flush, count); the state machine lives in instr_dispatcher.

Verification
REQ-034 Reset, then push 8'b00_00_01_00 with fsm_busy low -> fsm_instruction = 8'h04 for exactly one cycle, 2 cycles after transfer; 8'h00 otherwise.
REQ-035 Push 4 instructions (LOAD B0..B3) while model FSM holds busy 64 cycles each -> issued in order, one per busy period, queue_count 4,3,2,1,0; host_ready 0 while count=4.
REQ-036 Push 5th instruction while full -> not accepted; accepted the cycle after first pop.
REQ-037 fsm_busy never rises after issuing 8'b01_00_01_01 -> err_timeout=1 after 4 WAIT_BUSY cycles; next queued instruction still issues.
REQ-038 Queue 3 entries, assert flush with simultaneous push during WAIT_DONE -> queue_count 0, pushed entry dropped, current instruction completes, idle=1 after fsm_busy falls.
REQ-039 Push 8'h00 -> queue_count stays 0, no issue; assert reset during WAIT_DONE -> all outputs at reset values immediately.
